// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-port bundle for mem_port_arbiter.
// The master side holds the clients and the RAM; the slave side is the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 14
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data;

  logic [ADDR_WIDTH-1:0] port1_addr;
  logic [ADDR_WIDTH-1:0] port2_addr;
  logic [DATA_WIDTH-1:0] port1_data_in;
  logic [DATA_WIDTH-1:0] port2_data_in;
  logic                  port1_write_en;
  logic                  port2_write_en;
  logic [DATA_WIDTH-1:0] port1_data_out;
  logic [DATA_WIDTH-1:0] port2_data_out;

  modport master (
    output req_valid, req_write, req_addr, req_data, port1_data_out, port2_data_out,
    input  req_ready, rsp_valid, rsp_data,
    input  port1_addr, port2_addr, port1_data_in, port2_data_in, port1_write_en, port2_write_en
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, port1_data_out, port2_data_out,
    output req_ready, rsp_valid, rsp_data,
    output port1_addr, port2_addr, port1_data_in, port2_data_in, port1_write_en, port2_write_en
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the two ports of a dual-port block RAM among NUM_REQ
// requesters, with read-response routing through the RAM's fixed read pipeline.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 14,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IdW-1:0] id_t;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] dout_arr [2];

  id_t         rr_ptr_q, rr_ptr_d;
  logic        a_found, b_found;
  id_t         a_id, b_id;
  id_t         scan_idx;
  int unsigned scan_pos;
  logic        ww_conflict;
  logic        grant_a, grant_b;
  id_t         last_id;
  int unsigned next_pos;

  // Per-port read tracker; stage 0 is loaded on accept, the last stage drives rsp.
  logic trk_vld_q [2][READ_LATENCY];
  id_t  trk_id_q  [2][READ_LATENCY];
  logic push_vld  [2];
  id_t  push_id   [2];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    dout_arr[0] = bus.port1_data_out;
    dout_arr[1] = bus.port2_data_out;
  end

  // Rotating scan from rr_ptr: first valid requester is A, second is B.
  always_comb begin
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_id     = '0;
    b_id     = '0;
    scan_pos = 0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_pos = 32'(rr_ptr_q) + k;
      if (scan_pos >= NUM_REQ) begin
        scan_pos = scan_pos - NUM_REQ;
      end
      scan_idx = id_t'(scan_pos);
      if (bus.req_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_id    = scan_idx;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_id    = scan_idx;
        end
      end
    end
  end

  // Two writes to one address would collide in the RAM; B loses and port2 idles.
  assign ww_conflict = a_found && b_found && bus.req_write[a_id] && bus.req_write[b_id] &&
                       (addr_arr[a_id] == addr_arr[b_id]);
  assign grant_a     = a_found && !rst;
  assign grant_b     = b_found && !ww_conflict && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (grant_a) bus.req_ready[a_id] = 1'b1;
    if (grant_b) bus.req_ready[b_id] = 1'b1;
  end

  always_comb begin
    bus.port1_addr     = '0;
    bus.port1_data_in  = '0;
    bus.port1_write_en = 1'b0;
    bus.port2_addr     = '0;
    bus.port2_data_in  = '0;
    bus.port2_write_en = 1'b0;
    if (grant_a) begin
      bus.port1_addr     = addr_arr[a_id];
      bus.port1_data_in  = data_arr[a_id];
      bus.port1_write_en = bus.req_write[a_id];
    end
    if (grant_b) begin
      bus.port2_addr     = addr_arr[b_id];
      bus.port2_data_in  = data_arr[b_id];
      bus.port2_write_en = bus.req_write[b_id];
    end
  end

  always_comb begin
    last_id  = grant_b ? b_id : a_id;
    next_pos = 32'(last_id) + 1;
    if (next_pos >= NUM_REQ) begin
      next_pos = 0;
    end
    rr_ptr_d = grant_a ? id_t'(next_pos) : rr_ptr_q;
  end

  always_comb begin
    push_vld[0] = grant_a && !bus.req_write[a_id];
    push_id[0]  = a_id;
    push_vld[1] = grant_b && !bus.req_write[b_id];
    push_id[1]  = b_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int unsigned p = 0; p < 2; p++) begin
        for (int unsigned s = 0; s < READ_LATENCY; s++) begin
          trk_vld_q[p][s] <= 1'b0;
          trk_id_q[p][s]  <= '0;
        end
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned p = 0; p < 2; p++) begin
        trk_vld_q[p][0] <= push_vld[p];
        trk_id_q[p][0]  <= push_id[p];
        for (int unsigned s = 1; s < READ_LATENCY; s++) begin
          trk_vld_q[p][s] <= trk_vld_q[p][s-1];
          trk_id_q[p][s]  <= trk_id_q[p][s-1];
        end
      end
    end
  end

  // One grant per requester per cycle guarantees the two ports never target one slice.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!rst && trk_vld_q[p][READ_LATENCY-1] &&
            (trk_id_q[p][READ_LATENCY-1] == id_t'(i))) begin
          bus.rsp_valid[i]                       = 1'b1;
          bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = dout_arr[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural dual-port RAM, directed vector table,
// hand sequences and randomized traffic checked against a queue-based model.
module tb_mem_port_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 14;

  logic clk = 1'b0;
  logic rst;
  logic tb_init;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // RAM stand-in: address registered at the accept edge, data registered one edge later.
  logic [DW-1:0] ram [64];
  logic [AW-1:0] ra_q [2];
  logic [DW-1:0] rd_q [2];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else begin
      if (bus.port1_write_en) ram[bus.port1_addr] <= bus.port1_data_in;
      if (bus.port2_write_en) ram[bus.port2_addr] <= bus.port2_data_in;
    end
    ra_q[0] <= bus.port1_addr;
    ra_q[1] <= bus.port2_addr;
    rd_q[0] <= ram[ra_q[0]];
    rd_q[1] <= ram[ra_q[1]];
  end
  assign bus.port1_data_out = rd_q[0];
  assign bus.port2_data_out = rd_q[1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_rsp_t;

  logic [DW-1:0] mdl_mem [64];
  int            mdl_rr;
  exp_rsp_t      pend [$];

  function automatic logic [AW-1:0] addr_of(input int i);
    return bus.req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return bus.req_data[i*DW +: DW];
  endfunction

  always @(negedge clk) begin
    logic [N-1:0]    e_rv;
    logic [N*DW-1:0] e_rd;
    logic [N-1:0]    e_ready;
    logic [AW+DW:0]  e_p1, e_p2;
    exp_rsp_t        keep [$];
    int              cand [$];
    int              g [$];
    exp_rsp_t        r;
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    end
    e_rv = '0;
    e_rd = '0;
    keep = {};
    foreach (pend[j]) begin
      if (pend[j].due == cyc) begin
        e_rv[pend[j].id]            = 1'b1;
        e_rd[pend[j].id*DW +: DW]   = pend[j].data;
      end else begin
        keep.push_back(pend[j]);
      end
    end
    pend = keep;
    e_ready = '0;
    e_p1    = '0;
    e_p2    = '0;
    if (rst) begin
      e_rv   = '0;
      e_rd   = '0;
      pend   = {};
      mdl_rr = 0;
    end else begin
      cand = {};
      g    = {};
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mdl_rr + k) % N;
        if (bus.req_valid[i]) cand.push_back(i);
      end
      if (cand.size() >= 1) g.push_back(cand[0]);
      if (cand.size() >= 2 && !(bus.req_write[cand[0]] && bus.req_write[cand[1]] &&
                                addr_of(cand[0]) == addr_of(cand[1])))
        g.push_back(cand[1]);
      foreach (g[j]) e_ready[g[j]] = 1'b1;
      if (g.size() >= 1) e_p1 = {addr_of(g[0]), data_of(g[0]), bus.req_write[g[0]]};
      if (g.size() >= 2) e_p2 = {addr_of(g[1]), data_of(g[1]), bus.req_write[g[1]]};
      foreach (g[j]) if (bus.req_write[g[j]]) mdl_mem[addr_of(g[j])] = data_of(g[j]);
      foreach (g[j]) begin
        if (!bus.req_write[g[j]]) begin
          r.due  = cyc + 2;
          r.id   = g[j];
          r.data = mdl_mem[addr_of(g[j])];
          pend.push_back(r);
        end
      end
      if (g.size() > 0) mdl_rr = (g[g.size()-1] + 1) % N;
    end
    chk("mdl_rsp_valid", 64'(bus.rsp_valid), 64'(e_rv));
    chk("mdl_rsp_data", 64'(bus.rsp_data), 64'(e_rd));
    chk("mdl_req_ready", 64'(bus.req_ready), 64'(e_ready));
    chk("mdl_port1", 64'({bus.port1_addr, bus.port1_data_in, bus.port1_write_en}), 64'(e_p1));
    chk("mdl_port2", 64'({bus.port2_addr, bus.port2_data_in, bus.port2_write_en}), 64'(e_p2));
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [N-1:0]    valid;
    logic [N-1:0]    write;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    exp_ready;
    logic [AW-1:0]   exp_p1;
    logic [AW-1:0]   exp_p2;
    logic [1:0]      exp_we;
    logic [N-1:0]    exp_rv;
    logic [N*DW-1:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] w,
                              input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                              input logic [N-1:0] rdy, input logic [AW-1:0] p1,
                              input logic [AW-1:0] p2, input logic [1:0] we,
                              input logic [N-1:0] rv, input logic [N*DW-1:0] rd);
    vec_t t;
    t.valid = v; t.write = w; t.addr = a; t.data = d; t.exp_ready = rdy;
    t.exp_p1 = p1; t.exp_p2 = p2; t.exp_we = we; t.exp_rv = rv; t.exp_rd = rd;
    return t;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w,
                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t            vecs [14];
  logic [N*AW-1:0] a1234;
  logic [N*DW-1:0] dflt;
  logic [N*DW-1:0] slice;

  initial begin
    a1234 = {6'd4, 6'd3, 6'd2, 6'd1};
    dflt  = {14'h3, 14'h2, 14'h1, 14'h0};
    // {valid, write, addr, data, ready, p1, p2, we{p2,p1}, rsp_valid, rsp_data}
    vecs[0]  = mk(4'b1111, 4'b0000, a1234, dflt, 4'b0011, 6'd1, 6'd2, 2'b00, 4'b0000, '0);
    vecs[1]  = mk(4'b1111, 4'b0000, a1234, dflt, 4'b1100, 6'd3, 6'd4, 2'b00, 4'b0000, '0);
    vecs[2]  = mk(4'b1111, 4'b0000, a1234, dflt, 4'b0011, 6'd1, 6'd2, 2'b00, 4'b0011, '0);
    vecs[3]  = mk(4'b0000, 4'b0000, a1234, dflt, 4'b0000, 6'd0, 6'd0, 2'b00, 4'b1100, '0);
    vecs[4]  = mk(4'b0001, 4'b0001, {6'd4, 6'd3, 6'd2, 6'd9}, dflt,
                  4'b0001, 6'd9, 6'd0, 2'b01, 4'b0011, '0);
    vecs[5]  = mk(4'b1000, 4'b0000, a1234, dflt, 4'b1000, 6'd4, 6'd0, 2'b00, 4'b0000, '0);
    vecs[6]  = mk(4'b0011, 4'b0011, {6'd0, 6'd0, 6'd9, 6'd9}, {28'h0, 14'h0022, 14'h0011},
                  4'b0001, 6'd9, 6'd0, 2'b01, 4'b0000, '0);
    vecs[7]  = mk(4'b0011, 4'b0011, {6'd0, 6'd0, 6'd9, 6'd9}, {28'h0, 14'h0022, 14'h0011},
                  4'b0010, 6'd9, 6'd0, 2'b01, 4'b1000, '0);
    vecs[8]  = mk(4'b0100, 4'b0000, {6'd0, 6'd9, 6'd0, 6'd0}, dflt,
                  4'b0100, 6'd9, 6'd0, 2'b00, 4'b0000, '0);
    vecs[9]  = mk(4'b0011, 4'b0001, {6'd0, 6'd0, 6'd3, 6'd3}, {28'h0, 14'h0, 14'h0F0F},
                  4'b0011, 6'd3, 6'd3, 2'b01, 4'b0000, '0);
    vecs[10] = mk(4'b0101, 4'b0101, {6'd0, 6'd7, 6'd0, 6'd7}, dflt,
                  4'b0100, 6'd7, 6'd0, 2'b01, 4'b0100, {14'h0, 14'h0022, 28'h0});
    vecs[11] = mk(4'b1001, 4'b0000, {6'd5, 6'd0, 6'd0, 6'd6}, dflt,
                  4'b1001, 6'd5, 6'd6, 2'b00, 4'b0010, {28'h0, 14'h0F0F, 14'h0});
    vecs[12] = mk(4'b0000, 4'b0000, '0, '0, 4'b0000, 6'd0, 6'd0, 2'b00, 4'b0000, '0);
    vecs[13] = mk(4'b0000, 4'b0000, '0, '0, 4'b0000, 6'd0, 6'd0, 2'b00, 4'b1001, '0);

    // Reset with all requesters asking: nothing may be granted.
    rst     = 1'b1;
    tb_init = 1'b1;
    drive(4'b1111, 4'b0000, a1234, dflt);
    @(negedge clk);
    chk("reset_ready", 64'(bus.req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("reset_ports", 64'({bus.port1_addr, bus.port2_addr, bus.port1_write_en,
                            bus.port2_write_en}), 64'h0);
    repeat (3) next_cycle();
    rst     = 1'b0;
    tb_init = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_p1_addr", i), 64'(bus.port1_addr), 64'(vecs[i].exp_p1));
      chk($sformatf("vec%0d_p2_addr", i), 64'(bus.port2_addr), 64'(vecs[i].exp_p2));
      chk($sformatf("vec%0d_we", i), 64'({bus.port2_write_en, bus.port1_write_en}),
          64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'(vecs[i].exp_rv));
      chk($sformatf("vec%0d_rsp_data", i), 64'(bus.rsp_data), 64'(vecs[i].exp_rd));
      next_cycle();
    end

    // Single read: requester 3 preloads addr 5, requester 2 reads it back.
    drive(4'b1000, 4'b1000, {6'd5, 18'h0}, {14'h1ABC, 42'h0});
    next_cycle();
    drive(4'b0000, 4'b0000, '0, '0);
    next_cycle();
    drive(4'b0100, 4'b0000, {6'd0, 6'd5, 12'h0}, '0);
    @(negedge clk);
    chk("single_ready2", 64'(bus.req_ready[2]), 64'h1);
    chk("single_p1_addr", 64'(bus.port1_addr), 64'd5);
    next_cycle();
    drive(4'b0000, 4'b0000, '0, '0);
    @(negedge clk);
    chk("single_rsp_early", 64'(bus.rsp_valid[2]), 64'h0);
    next_cycle();
    @(negedge clk);
    slice = bus.rsp_data;
    chk("single_rsp_valid", 64'(bus.rsp_valid[2]), 64'h1);
    chk("single_rsp_data", 64'(slice[2*DW +: DW]), 64'h1ABC);
    next_cycle();
    @(negedge clk);
    chk("single_rsp_late", 64'(bus.rsp_valid[2]), 64'h0);
    next_cycle();

    // Reset while two reads are in flight.
    drive(4'b0011, 4'b0000, a1234, dflt);
    @(negedge clk);
    chk("midrst_accept", 64'(bus.req_ready), 64'b0011);
    next_cycle();
    rst = 1'b1;
    drive(4'b0000, 4'b0000, '0, '0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_rsp", 64'(bus.rsp_valid), 64'h0);
    chk("midrst_ports", 64'({bus.port1_addr, bus.port2_addr, bus.port1_data_in,
                             bus.port2_data_in, bus.port1_write_en, bus.port2_write_en}), 64'h0);
    next_cycle();
    drive(4'b1111, 4'b0000, a1234, dflt);
    @(negedge clk);
    chk("midrst_rr_zero", 64'(bus.req_ready), 64'b0011);
    next_cycle();

    // Randomized traffic with narrow addresses to provoke conflicts and forwarding.
    for (int c = 0; c < 400; c++) begin
      logic [N*AW-1:0] ra;
      logic [N*DW-1:0] rd;
      for (int i = 0; i < N; i++) begin
        ra[i*AW +: AW] = AW'($urandom_range(0, 7));
        rd[i*DW +: DW] = DW'($urandom);
      end
      rst = ($urandom_range(0, 39) == 0);
      drive(N'($urandom), N'($urandom), ra, rd);
      next_cycle();
    end
    rst = 1'b0;
    drive('0, '0, '0, '0);
    repeat (3) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the two ports of the 64x14 dual-port block RAM among `NUM_REQ` requesters. Each cycle it grants up to two requests (one per RAM port) and drives the RAM port address, data and write-enable lines. It also tracks in-flight reads through the RAM's two-cycle read pipeline and returns the read data to the originating requester. It sits between the client blocks and the `Memory` instance; the RAM itself is unchanged.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 6: RAM address width.
- `DATA_WIDTH`, default 14: RAM word width.
- `READ_LATENCY`, default 2: cycles from accept to read data; fixed by the RAM; only the value 2 is supported.

Ports:
- `clk` in 1: single clock; drives the arbiter and both RAM port clocks.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester grant. Combinational; a request is accepted when valid&ready.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_WIDTH: flattened addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data` in NUM_REQ*DATA_WIDTH: flattened write data.
- `rsp_valid` out NUM_REQ: per-requester read-data strobe, one cycle.
- `rsp_data` out NUM_REQ*DATA_WIDTH: flattened read data. Valid only with `rsp_valid`.
- `port1_addr`, `port2_addr` out ADDR_WIDTH: RAM port addresses.
- `port1_data_in`, `port2_data_in` out DATA_WIDTH: RAM write data.
- `port1_write_en`, `port2_write_en` out 1: RAM write enables.
- `port1_data_out`, `port2_data_out` in DATA_WIDTH: RAM read data.

## Operation
- State: round-robin pointer `rr_ptr` (log2 NUM_REQ bits); a read tracker with 2 stages per port, each stage holding {valid, requester id}.
- Selection, each cycle:
  - Scan requesters with `req_valid`=1 in order rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - The first hit is candidate A and goes to port1.
  - The next hit is candidate B and goes to port2.
- Write-write conflict: if A and B are both writes to the same address, only A is granted. B is not granted, and no substitute is picked for port2 this cycle.
- A read and a write to the same address in the same cycle is legal. The read returns the newly written data, because the RAM samples the address before reading.
- At most one grant per requester per cycle.
- Idle port: address, data and write_en driven to 0.
- Pointer update: if any grant occurs, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. Otherwise rr_ptr holds.
- Granted read: push {1, id} into the stage-0 tracker of the port used. Stage 0 advances to stage 1 each cycle.
- When a port's stage 1 is valid:
  - `rsp_valid[id]` = 1.
  - `rsp_data[id]` = that port's `data_out`.
  - All other rsp slices are 0.
- Writes produce no response.
- Responses have no backpressure. Because one requester is granted at most once per cycle, at most one response per requester per cycle can occur.

## Timing
- Reset: rr_ptr=0, trackers cleared, `rsp_valid`=0, `req_ready`=0 while `rst`=1, all RAM port outputs 0.
- Reset mid-operation: in-flight reads are discarded; no `rsp_valid` fires for reads accepted before reset.
- Accept in cycle T. A write lands in RAM at the edge ending cycle T.
- Read accepted in cycle T: `rsp_valid` is high during cycle T+2, exactly once.
- Throughput: up to 2 accesses per cycle, back-to-back, with no bubbles.
- `req_ready` depends combinationally on `req_valid`, `req_write`, `req_addr` and `rr_ptr`. It must not depend on any `rsp_*` signal.
- Fairness: a requester holding `req_valid` continuously is granted within ceil(NUM_REQ/2) cycles, excluding cycles lost to write-write conflicts. It is always granted within NUM_REQ cycles.

## Test plan
- Single read: after reset, preload RAM addr 5 = 0x1ABC; requester 2 reads addr 5 in cycle 10. Expect `req_ready[2]`=1 and port1_addr=5 in cycle 10, then `rsp_valid[2]`=1 with data 0x1ABC in cycle 12 and in no other cycle.
- Dual grant: all 4 requesters request every cycle from rr_ptr=0. Expect grants {0,1}, {2,3}, {0,1}, … with 0/2 on port1 and 1/3 on port2.
- Write conflict: requesters 0 and 1 both write addr 9 (0x0011, 0x0022) at rr_ptr=0. Expect only 0 granted (port2 idle) and rr_ptr=1. Next cycle 1 is granted; RAM[9] reads back 0x0022.
- Read-after-write same cycle: requester 0 writes addr 3 = 0x0F0F on port1 while requester 1 reads addr 3 on port2. Expect `rsp_data[1]`=0x0F0F two cycles later.
- Reset mid-flight: accept reads on both ports in cycle T and assert `rst` in cycle T+1. Expect no `rsp_valid` in T+2. After reset: rr_ptr=0 and all outputs 0.
